ila_capture_core: RTL
=====================

# ila_capture_core

On-chip capture engine that receives the probe bus and clock of an `FPGA_ILA` instrumentation block. It stores a pre/post-trigger window of probe samples in a circular RAM. After capture completes, it streams the window out oldest-first as bytes over a valid/ready interface, which a debug UART or JTAG bridge consumes.

## Interface
Parameters:
- `PROBE_W`, 32, probe bus width (1..256)
- `DEPTH`, 256, sample buffer depth; must be a power of two, ≥ 4
- `PRE_TRIG`, 64, samples kept before the trigger sample; must satisfy 1 ≤ `PRE_TRIG` ≤ `DEPTH`-1

Ports:
- `clk`  in  1  sole clock; all probe sampling and readout run on it
- `rst`  in  1  synchronous, active-high reset
- `probe`  in  PROBE_W  signals under observation, sampled every cycle
- `arm`  in  1  one-cycle start pulse, honoured only in IDLE
- `trig_mask`  in  PROBE_W  per-bit compare enable; all-zero means trigger immediately
- `trig_value`  in  PROBE_W  compare value
- `rd_data`  out  8  dump byte
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  consumer accepts the byte when `rd_valid` and `rd_ready` are both high
- `busy`  out  1  high in every state except IDLE
- `triggered`  out  1  high from the cycle after the trigger until the next `arm`

## Operation
- Match condition: `((probe ^ trig_value) & trig_mask) == 0`.
- Derived constants:
  - `BYTES = ceil(PROBE_W/8)`
  - `AW = log2(DEPTH)`
- States: IDLE → PRE → WAIT → POST → DUMP → IDLE.
- IDLE: no writes. `arm` loads `wr_ptr=0` and `pre_cnt=0`, clears `triggered`, and goes to PRE.
- PRE:
  - Write `probe` to `mem[wr_ptr]` and increment `wr_ptr` each cycle.
  - The trigger is not evaluated in PRE.
  - After `PRE_TRIG` writes, go to WAIT.
- WAIT:
  - Write every cycle; `wr_ptr` wraps modulo DEPTH.
  - On the first cycle where the match condition holds, that sample is written and `trig_ptr=wr_ptr`.
  - If `DEPTH-PRE_TRIG-1 == 0`, go straight to DUMP; otherwise go to POST with `post_cnt = DEPTH-PRE_TRIG-1`.
- POST: write every cycle and decrement `post_cnt`. When it reaches 0 after the final write, go to DUMP.
- DUMP:
  - Start address is `(trig_ptr - PRE_TRIG) mod DEPTH`. Read DEPTH samples in address order with wrap.
  - Each sample is sent as `BYTES` bytes, least-significant byte first, with the top byte zero-padded.
  - After the last byte is accepted, go to IDLE.
- Total bytes per dump: `DEPTH*BYTES`.
- The trigger sample is at sample index `PRE_TRIG` of the dump.
- `arm` outside IDLE, including during DUMP, is ignored.

## Timing
- Reset values: `rd_valid=0`, `rd_data=0`, `busy=0`, `triggered=0`, state IDLE, all pointers and counters 0. RAM contents are not cleared.
- `rst` mid-capture or mid-dump:
  - Abort immediately; the next cycle is IDLE with outputs at reset values.
  - A partially sent dump is not resumed.
- `arm` at cycle t: the first sample written is `probe` at t+1, and `busy` is high at t+1.
- Trigger sample at cycle t: `triggered` is high at t+1.
- RAM read has 1-cycle latency; one prefetched sample register sits in front of the byte mux.
- The first `rd_valid` is asserted no later than 2 cycles after entering DUMP.
- Throughput: one byte per cycle while `rd_ready` stays high; there are no bubbles at sample boundaries.
- Handshake rules:
  - While `rd_valid` is high and `rd_ready` is low, `rd_data` and `rd_valid` hold stable.
  - `rd_valid` never drops without a transfer.
- `busy` falls in the cycle after the final byte transfer.

## Configuration
- `ILA_TRIG_EDGE_EN` defined: the trigger fires only when the match condition is true this cycle and was false on the previous sampled cycle.
  - The previous-match flag is registered throughout PRE.
  - A match that is already true on entry to WAIT after being true in PRE does not fire.
- `ILA_TRIG_EDGE_EN` undefined: the trigger fires on a level match. No previous-match register exists.

## Structure
- Shared package `ila_pkg`:
  - State enum `ila_state_t` (IDLE, PRE, WAIT, POST, DUMP)
  - Function `ila_bytes(width)` returning `ceil(width/8)`
  - Constant `ILA_BYTE_W = 8`
- One sub-module `ila_sample_ram`: simple dual-port RAM, DEPTH×PROBE_W, one write port, registered read with 1-cycle latency, no reset on storage.
- The top level holds the FSM, counters, trigger compare, prefetch register and byte serializer.

## Test plan
- Level trigger: `PROBE_W=12`, `DEPTH=16`, `PRE_TRIG=4`, `probe` = free-running counter starting at 0 on the cycle after `arm`, `trig_mask=0xFFF`, `trig_value=0x009`, `rd_ready=1`.
  - Expect 32 bytes forming samples 5..20 little-endian; sample 4 of the dump is `0x009`.
  - Expect `triggered` one cycle after `probe==9`.
- Mask all-zero with the same setup: the trigger fires on the first WAIT sample. The dump is samples 0..15, and the trigger sample is index 4 with value 4.
- Backpressure: toggle `rd_ready` 1-of-3 cycles pseudo-randomly during the dump.
  - The byte sequence must be identical to the first scenario.
  - `rd_data` stays stable while `rd_valid && !rd_ready`.
- Wrap with delayed trigger: `trig_value=0x02A`.
  - `trig_ptr` wraps past 15.
  - The dump starts at `(trig_ptr-4) mod 16` and yields samples 38..53.
- Reset mid-dump: assert `rst` after 10 accepted bytes.
  - Next cycle: `rd_valid=0`, `busy=0`.
  - A new `arm` produces a complete, correct 32-byte dump.
- `ILA_TRIG_EDGE_EN`: hold `probe=0x009` constant with mask `0xFFF`.
  - Macro defined: no trigger, `busy` stays high.
  - Macro undefined: trigger on the first WAIT sample.
  - `arm` pulses during WAIT are ignored in both builds.

Source files
------------

// File: rtl/ila_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ila_pkg                                                                  |
// | Shared state encoding and sizing helpers for the ILA capture core.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ila_pkg;

    localparam int ILA_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DUMP = 3'd4
    } ila_state_t;

    function automatic int ila_bytes(input int width);
        return (width + ILA_BYTE_W - 1) / ILA_BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ila_capture_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ila_capture_core_if                                                      |
// | Byte-wide valid/ready dump stream from the capture core to its consumer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ila_capture_core_if;
    import ila_pkg::*;

    logic [ILA_BYTE_W-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);

endinterface
`default_nettype wire

// File: rtl/ila_sample_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ila_sample_ram                                                           |
// | Simple dual-port sample store, registered read, storage not reset.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ila_sample_ram #(
    parameter int DEPTH   = 256,
    parameter int PROBE_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PROBE_W-1:0]       wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PROBE_W-1:0]       rdata
);

    logic [PROBE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        // rdata holds when re is low; the reader relies on this as a skid stage
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ila_capture_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ila_capture_core                                                         |
// | Pre/post-trigger probe capture into a circular RAM, dumped oldest-first  |
// | as LSB-first bytes. ILA_TRIG_EDGE_EN selects rising-edge triggering.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ila_capture_core
    import ila_pkg::*;
#(
    parameter int PROBE_W  = 32,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PROBE_W-1:0]        probe,
    input  logic                      arm,
    input  logic [PROBE_W-1:0]        trig_mask,
    input  logic [PROBE_W-1:0]        trig_value,
    ila_capture_core_if.master        rd,
    output logic                      busy,
    output logic                      triggered
);

    localparam int c_BYTES = ila_bytes(PROBE_W);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_BIW   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_POST  = DEPTH - PRE_TRIG - 1;

    localparam logic [c_AW-1:0]  c_PRE_LAST  = c_AW'(PRE_TRIG - 1);
    localparam logic [c_AW-1:0]  c_PRE_OFS   = c_AW'(PRE_TRIG);
    localparam logic [c_AW-1:0]  c_POST_INIT = c_AW'(c_POST);
    localparam logic [c_AW:0]    c_DEPTH_CNT = (c_AW+1)'(DEPTH);
    localparam logic [c_BIW-1:0] c_LAST_BYTE = c_BIW'(c_BYTES - 1);

    ila_state_t r_state, w_state_nxt;

    logic [c_AW-1:0]    r_wr_ptr, r_pre_cnt, r_post_cnt, r_trig_ptr;
    logic [c_AW:0]      r_issued, r_popped;
    logic [c_BIW-1:0]   r_byte_idx;
    logic               r_q_valid, r_pref_valid;
    logic [PROBE_W-1:0] r_pref, w_ram_q;
    logic [c_BYTES*ILA_BYTE_W-1:0] w_pad;

    logic w_match, w_fire, w_we, w_xfer, w_pop, w_pref_load, w_issue, w_done;
    logic [c_AW-1:0] w_rd_addr;

    assign w_match = ((probe ^ trig_value) & trig_mask) == '0;

`ifdef ILA_TRIG_EDGE_EN
    logic r_prev_match;

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
            r_prev_match <= 1'b0;
        end else begin
            r_prev_match <= w_match;
        end
    end

    assign w_fire = (r_state == WAIT) && w_match && !r_prev_match;
`else
    assign w_fire = (r_state == WAIT) && w_match;
`endif

    assign w_we = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);

    // Two-deep read pipeline: the RAM output register holds an unconsumed
    // sample while the prefetch register is still being serialized.
    assign w_xfer      = r_pref_valid && rd.rd_ready;
    assign w_pop       = w_xfer && (r_byte_idx == c_LAST_BYTE);
    assign w_pref_load = r_q_valid && (!r_pref_valid || w_pop);
    assign w_issue     = (r_state == DUMP) && (r_issued != c_DEPTH_CNT) &&
                         (!r_q_valid || w_pref_load);
    assign w_done      = w_pop && (r_popped == c_DEPTH_CNT - 1'b1);
    assign w_rd_addr   = r_trig_ptr - c_PRE_OFS + r_issued[c_AW-1:0];

    ila_sample_ram #(
        .DEPTH   (DEPTH),
        .PROBE_W (PROBE_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (probe),
        .re    (w_issue),
        .raddr (w_rd_addr),
        .rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (arm) w_state_nxt = PRE;
            PRE:     if (r_pre_cnt == c_PRE_LAST) w_state_nxt = WAIT;
            WAIT:    if (w_fire) w_state_nxt = (c_POST == 0) ? DUMP : POST;
            POST:    if (r_post_cnt == c_AW'(1)) w_state_nxt = DUMP;
            DUMP:    if (w_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_trig_ptr   <= '0;
            r_issued     <= '0;
            r_popped     <= '0;
            r_byte_idx   <= '0;
            r_q_valid    <= 1'b0;
            r_pref_valid <= 1'b0;
            r_pref       <= '0;
            triggered    <= 1'b0;
        end else begin
            if (w_issue) r_issued <= r_issued + 1'b1;
            if (w_pop)   r_popped <= r_popped + 1'b1;
            r_q_valid <= w_issue || (r_q_valid && !w_pref_load);
            if (w_pref_load) begin
                r_pref       <= w_ram_q;
                r_pref_valid <= 1'b1;
            end else if (w_pop) begin
                r_pref_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_byte_idx <= (r_byte_idx == c_LAST_BYTE) ? '0 : r_byte_idx + 1'b1;
            end
            if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;

            case (r_state)
                IDLE: if (arm) begin
                    r_wr_ptr   <= '0;
                    r_pre_cnt  <= '0;
                    r_issued   <= '0;
                    r_popped   <= '0;
                    r_byte_idx <= '0;
                    triggered  <= 1'b0;
                end
                PRE:  r_pre_cnt <= r_pre_cnt + 1'b1;
                WAIT: if (w_fire) begin
                    r_trig_ptr <= r_wr_ptr;
                    r_post_cnt <= c_POST_INIT;
                    triggered  <= 1'b1;
                end
                POST: r_post_cnt <= r_post_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_pad              = '0;
        w_pad[PROBE_W-1:0] = r_pref;
    end

    assign rd.rd_data  = w_pad[r_byte_idx*ILA_BYTE_W +: ILA_BYTE_W];
    assign rd.rd_valid = r_pref_valid;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
